trace_record_emitter: RTL
=========================

// Module: trace_record_emitter
// PURPOSE
//   Sits beside the five-stage pipeline's writeback/memory stages and turns per-cycle retire
//   events (register write, load, store, halt) into a stream of typed trace records.
//   Records are buffered in a multi-push FIFO and leave through a valid/ready port to an
//   on-chip logger or debug UART. It is the producer side of the REG/LOAD/STORE/HALT
//   trace, so hardware runs yield the same trace as simulation.
// PARAMETERS
//   DEPTH_LOG2   4   FIFO depth = 2**DEPTH_LOG2 records; legal range 2..8
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   rst          in   1   asynchronous, active-high reset
//   en           in   1   trace enable; when 0, inputs are ignored and counters hold
//   reg_write    in   1   register file written this cycle
//   write_reg    in   4   destination register
//   write_data   in  16   data written to register
//   mem_read     in   1   data memory read this cycle
//   mem_write    in   1   data memory write this cycle
//   mem_addr     in  16   data memory address
//   mem_rdata    in  16   data read from memory
//   mem_wdata    in  16   data written to memory
//   hlt          in   1   halt in memory/writeback stage
//   rec_valid    out  1   head record available
//   rec_ready    in   1   consumer accepts head record
//   rec_type     out  2   00 REG, 01 LOAD, 10 STORE, 11 HALT
//   rec_key      out 16   REG: {12'b0,write_reg}; LOAD/STORE: mem_addr; HALT: cycle count
//   rec_value    out 16   REG: write_data; LOAD: mem_rdata; STORE: mem_wdata; HALT: inst count
//   overflow     out  1   sticky: at least one event cycle was dropped
//   halted       out  1   halt seen; no further events accepted
//   done         out  1   HALT record consumed and FIFO empty
// BEHAVIOUR
//   - Reset (async, immediate): FIFO empty, rec_valid=0, rec_type/key/value=0, overflow=0,
//     halted=0, done=0, cyc_cnt=0, inst_cnt=0, FSM=RUN. Reset mid-stream discards all records.
//   - Counters (16-bit, wrap): cyc_cnt +1 every cycle with en=1 in RUN. inst_cnt +1 in each
//     accepted cycle with reg_write|mem_write|hlt.
//   - Event cycle (en=1, RUN): n = reg_write+mem_read+mem_write+hlt (0..4). free = DEPTH-count,
//     sampled before this cycle's pop.
//   - If n<=free: push all n records into consecutive slots in the fixed order REG, LOAD,
//     STORE, HALT. HALT carries the post-increment cyc_cnt and inst_cnt.
//   - If n>free: drop the whole cycle; no partial push; set overflow; counters still update.
//     A dropped hlt still moves the FSM to HALT_PEND.
//   - FSM RUN: stays while no hlt. Goes to HALTED if hlt is accepted, or to HALT_PEND if hlt
//     is dropped. halted=1 from the edge where hlt is sampled.
//   - FSM HALT_PEND: inputs ignored; pushes the HALT record with the saved counters on the
//     first cycle with free>=1, then goes to HALTED.
//   - FSM HALTED: inputs ignored; goes to DONE when FIFO empty (after last pop).
//   - FSM DONE: done=1, sticky until rst.
//   - Output: show-ahead FIFO; rec_* driven from head and held stable while
//     rec_valid && !rec_ready.
//   - Pop on rec_valid && rec_ready. Push and pop in the same cycle are both performed.
//     Count changes by n-1.
//   - Latency: events sampled at edge k appear on rec_* after edge k (1 cycle) if the FIFO
//     was empty.
//   - Pointers wrap modulo DEPTH; full = count==DEPTH; rec_valid = count!=0.
// TESTING
//   1 Event: reg_write=1, write_reg=3, write_data=0x0005, rec_ready=1 -> next cycle rec_valid=1,
//     type 00, key 0x0003, value 0x0005; then empty.
//   2 One cycle with reg_write r1=0x1111 and mem_write addr 0x0040 wdata 0xBEEF, rec_ready=0
//     -> two records, REG then STORE {10,0x0040,0xBEEF}, rec_* stable until ready.
//   3 Fill DEPTH=16 with ready=0, pop 1, then present a reg+load+store cycle -> all dropped,
//     overflow=1, count stays 15.
//   4 hlt on the 10th enabled cycle after 4 counted events -> HALT {11,0x000A,0x0005};
//     halted=1; later reg_write ignored; done=1 after drain.
//   5 hlt while FIFO full -> overflow=1, HALT_PEND. After one pop, HALT pushed with saved
//     counters; done after drain.
//   6 rst pulse while 5 records queued and ready=0 -> rec_valid=0 immediately, counters 0;
//     post-reset event traced normally.

Source files
------------

// File: rtl/trace_record_emitter.sv
// trace_record_emitter
//   Turns per-cycle retire events from the pipeline (register write, load, store,
//   halt) into typed trace records. Up to four records per cycle are pushed into a
//   show-ahead FIFO and leave through a valid/ready port.
//
//   State table
//     S_RUN       | accepting events while en=1
//     S_HALT_PEND | halt was dropped; waiting for one free slot to push HALT
//     S_HALTED    | halt recorded; waiting for the FIFO to drain
//     S_DONE      | HALT consumed and FIFO empty; sticky until rst
//
// Ports
//   clk, rst                        clock, async active-high reset
//   en                              trace enable
//   reg_write/write_reg/write_data  register file write event
//   mem_read/mem_write/mem_addr/
//   mem_rdata/mem_wdata             data memory access events
//   hlt                             halt event
//   rec_valid/rec_ready             record handshake
//   rec_type/rec_key/rec_value      head record fields
//   overflow                        sticky: an event cycle was dropped
//   halted, done                    halt seen / trace complete
module trace_record_emitter #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] mem_wdata,
  input  logic        hlt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [1:0]  rec_type,
  output logic [15:0] rec_key,
  output logic [15:0] rec_value,
  output logic        overflow,
  output logic        halted,
  output logic        done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_RUN, S_HALT_PEND, S_HALTED, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [33:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     cyc_q, cyc_d, inst_q, inst_d;
  logic            overflow_q, overflow_d;

  logic            active, fits, push_ev, pend_push, pop, halt_push;
  logic [2:0]      ev_n, push_n;
  logic [CW-1:0]   free;
  logic [AW-1:0]   idx_reg, idx_load, idx_store, idx_halt;
  logic [33:0]     halt_rec, head;

  always_comb begin
    active    = en && (state_q == S_RUN);
    ev_n      = 3'(reg_write) + 3'(mem_read) + 3'(mem_write) + 3'(hlt);
    free      = CW'(DEPTH) - count_q;
    fits      = CW'(ev_n) <= free;
    push_ev   = active && fits;
    // Free space is judged before this cycle's pop, so a full FIFO waits a cycle.
    pend_push = (state_q == S_HALT_PEND) && (count_q != CW'(DEPTH));
    pop       = (count_q != '0) && rec_ready;
    halt_push = (push_ev && hlt) || pend_push;
    push_n    = push_ev ? ev_n : {2'b00, pend_push};

    // Records pack into consecutive slots in REG, LOAD, STORE, HALT order.
    idx_reg   = wr_ptr_q;
    idx_load  = wr_ptr_q + AW'(reg_write);
    idx_store = wr_ptr_q + AW'(3'(reg_write) + 3'(mem_read));
    idx_halt  = push_ev ? wr_ptr_q + AW'(3'(reg_write) + 3'(mem_read) + 3'(mem_write))
                        : wr_ptr_q;

    cyc_d      = active ? cyc_q + 16'd1 : cyc_q;
    inst_d     = (active && (reg_write || mem_write || hlt)) ? inst_q + 16'd1 : inst_q;
    // Counters freeze outside RUN, so in HALT_PEND they still hold the halt-cycle values.
    halt_rec   = {2'b11, cyc_d, inst_d};
    overflow_d = overflow_q || (active && !fits);

    count_d  = count_q + CW'(push_n) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push_n);
    rd_ptr_d = rd_ptr_q + AW'(pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:       if (active && hlt) state_d = fits ? S_HALTED : S_HALT_PEND;
      S_HALT_PEND: if (pend_push) state_d = S_HALTED;
      S_HALTED:    if (count_q == '0) state_d = S_DONE;
      default:     state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      inst_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_ev && reg_write) mem_q[idx_reg]   <= {2'b00, 12'b0, write_reg, write_data};
    if (push_ev && mem_read)  mem_q[idx_load]  <= {2'b01, mem_addr, mem_rdata};
    if (push_ev && mem_write) mem_q[idx_store] <= {2'b10, mem_addr, mem_wdata};
    if (halt_push)            mem_q[idx_halt]  <= halt_rec;
  end

  assign head      = mem_q[rd_ptr_q];
  assign rec_valid = (count_q != '0);
  assign {rec_type, rec_key, rec_value} = rec_valid ? head : 34'b0;
  assign overflow  = overflow_q;
  assign halted    = (state_q != S_RUN);
  assign done      = (state_q == S_DONE);

endmodule
